// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR control sequencer and its helpers.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        DRAIN   = 3'd4,
        OUT     = 3'd5,
        DONE    = 3'd6
    } fir_state_e;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;
    localparam int         WORD_SHIFT  = 2;

endpackage

// File: rtl/fir_ring_addr.sv
// Mod-N ring arithmetic for the data-RAM circular buffer: pointer advance
// and the (wptr - k) mod N read index used while walking the taps.
module fir_ring_addr #(
    parameter int N     = 11,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] wptr,
    input  logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] wptr_inc,
    output logic [IDX_W-1:0] rd_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] N_W  = IDX_W'(N);

    // Underflow is corrected by adding N; the true result is always below N,
    // so modular IDX_W-bit arithmetic yields it exactly.
    always_comb begin
        wptr_inc = (wptr == LAST) ? '0 : wptr + 1'b1;
        rd_idx   = (wptr >= k) ? (wptr - k) : (wptr - k + N_W);
    end

endmodule

// File: rtl/fir_sched.sv
// Control sequencer for the FIR engine: owns the tap/data BRAM ports, the
// circular write pointer and the accept -> MAC -> output phase sequencing.
module fir_sched
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     ap_start,
    output logic                     ap_start_ack,
    output logic                     ap_idle,
    output logic                     ap_done,
    input  logic                     cfg_tap_req,
    input  logic                     cfg_tap_we,
    input  logic [pADDR_WIDTH-1:0]   cfg_tap_addr,
    output logic                     cfg_tap_gnt,
    output logic                     tap_EN,
    output logic [pDATA_WIDTH/8-1:0] tap_WE,
    output logic [pADDR_WIDTH-1:0]   tap_A,
    output logic                     data_EN,
    output logic [pDATA_WIDTH/8-1:0] data_WE,
    output logic [pADDR_WIDTH-1:0]   data_A,
    output logic                     data_zero,
    input  logic                     ss_tvalid,
    input  logic                     ss_tlast,
    output logic                     ss_tready,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic                     sm_tvalid,
    input  logic                     sm_tready,
    output logic                     sm_tlast,
    output fir_state_e               dbg_state
);

    localparam int                   IDX_W  = $clog2(Tape_Num);
    localparam int                   WE_W   = pDATA_WIDTH / 8;
    localparam logic [WE_W-1:0]      WE_ALL = WE_W'(BYTE_EN_ALL);
    localparam logic [IDX_W-1:0]     K_LAST = IDX_W'(Tape_Num - 1);

    fir_state_e       state, state_n;
    logic [IDX_W-1:0] k, k_n;
    logic [IDX_W-1:0] wptr, wptr_n;
    logic [IDX_W-1:0] wptr_inc, rd_idx;
    logic             last_q, last_load;

    function automatic logic [pADDR_WIDTH-1:0] to_byte(input logic [IDX_W-1:0] idx);
        return pADDR_WIDTH'(idx) << WORD_SHIFT;
    endfunction

    fir_ring_addr #(
        .N     (Tape_Num),
        .IDX_W (IDX_W)
    ) u_ring (
        .wptr     (wptr),
        .k        (k),
        .wptr_inc (wptr_inc),
        .rd_idx   (rd_idx)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state  <= IDLE;
            k      <= '0;
            wptr   <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            wptr  <= wptr_n;
            if (last_load) begin
                last_q <= ss_tlast;
            end
        end
    end

    always_comb begin
        state_n      = state;
        k_n          = k;
        wptr_n       = wptr;
        last_load    = 1'b0;
        ap_start_ack = 1'b0;
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        cfg_tap_gnt  = 1'b0;
        tap_EN       = 1'b0;
        tap_WE       = '0;
        tap_A        = '0;
        data_EN      = 1'b0;
        data_WE      = '0;
        data_A       = '0;
        data_zero    = 1'b0;
        ss_tready    = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        sm_tvalid    = 1'b0;
        sm_tlast     = 1'b0;

        // Outputs read as idle while reset is held, whatever the current state.
        if (axis_rst) begin
            ap_idle = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ap_idle = 1'b1;
                    if (ap_start && !cfg_tap_req) begin
                        ap_start_ack = 1'b1;
                        k_n          = '0;
                        state_n      = CLEAR;
                    end
                end
                CLEAR: begin
                    data_EN   = 1'b1;
                    data_WE   = WE_ALL;
                    data_A    = to_byte(k);
                    data_zero = 1'b1;
                    if (k == K_LAST) begin
                        k_n     = '0;
                        wptr_n  = '0;
                        state_n = WAIT_IN;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
                WAIT_IN: begin
                    ss_tready = 1'b1;
                    if (ss_tvalid) begin
                        data_EN   = 1'b1;
                        data_WE   = WE_ALL;
                        data_A    = to_byte(wptr);
                        last_load = 1'b1;
                        k_n       = '0;
                        state_n   = MAC;
                    end
                end
                MAC: begin
                    // BRAM read latency puts each product one cycle behind its address.
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = to_byte(k);
                    data_A  = to_byte(rd_idx);
                    mac_en  = (k != '0);
                    mac_clr = (k == IDX_W'(1));
                    if (k == K_LAST) begin
                        k_n     = '0;
                        state_n = DRAIN;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
                DRAIN: begin
                    mac_en  = 1'b1;
                    state_n = OUT;
                end
                OUT: begin
                    sm_tvalid = 1'b1;
                    sm_tlast  = last_q;
                    if (sm_tready) begin
                        wptr_n  = wptr_inc;
                        state_n = last_q ? DONE : WAIT_IN;
                    end
                end
                DONE: begin
                    ap_done = 1'b1;
                    ap_idle = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    k_n     = '0;
                    state_n = IDLE;
                end
            endcase

            if ((state == IDLE || state == DONE) && cfg_tap_req) begin
                cfg_tap_gnt = 1'b1;
                tap_EN      = 1'b1;
                tap_A       = cfg_tap_addr;
                tap_WE      = cfg_tap_we ? WE_ALL : '0;
            end
        end
    end

    assign dbg_state = state;

endmodule
